// File: rtl/restart_alarm_pkg.sv
// Shared timer/alarm definitions: restart FSM encoding, cause bit indices
// and the default scan-tick limits used by restart_alarm.
package restart_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_WAIT_REL = 2'd3
  } alarm_state_e;

  localparam int CAUSE_PAR    = 0;
  localparam int CAUSE_NW     = 1;
  localparam int CAUSE_TC     = 2;
  localparam int CAUSE_LOCK   = 3;
  localparam int CAUSE_NORUPT = 4;
  localparam int CAUSE_ACKTO  = 5;
  localparam int CAUSE_W      = 6;

  localparam int NW_TICKS_DEF    = 2;
  localparam int TC_TICKS_DEF    = 1;
  localparam int RUPT_TICKS_DEF  = 3;
  localparam int GOJ_CYCLES_DEF  = 4;
  localparam int GOJ_TIMEOUT_DEF = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/restart_alarm_if.sv
// goj1/gojam restart handshake between the alarm (initiator) and the timer.
// Handshake: goj1 is a request held high for a fixed number of cycles; the
// timer acknowledges by raising gojam (a level) and releases by dropping it.
interface restart_alarm_if;
  logic goj1;
  logic gojam;

  modport master (output goj1, input gojam);
  modport slave  (input goj1, output gojam);
endinterface

// File: rtl/restart_alarm_tick_counter.sv
// Scan-tick counter that pulses alarm on the tick that would reach LIMIT,
// then clears itself so it never wraps.
module alarm_tick_counter #(
  parameter int LIMIT = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic alarm
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // clr dominates inc, so a coincident clear suppresses the alarm.
  assign alarm = inc && !clr && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clock) begin
    if (rst || clr || alarm) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/restart_alarm.sv
// Watchdog that monitors program behaviour against the scan tick, latches
// alarm causes and drives the goj1 restart request into the timer.
module restart_alarm
  import restart_alarm_pkg::*;
#(
  parameter int NW_TICKS    = NW_TICKS_DEF,
  parameter int TC_TICKS    = TC_TICKS_DEF,
  parameter int RUPT_TICKS  = RUPT_TICKS_DEF,
  parameter int GOJ_CYCLES  = GOJ_CYCLES_DEF,
  parameter int GOJ_TIMEOUT = GOJ_TIMEOUT_DEF
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 nw_access,
  input  logic                 inst_done,
  input  logic                 inst_is_tc,
  input  logic                 in_rupt,
  input  logic                 par_fail,
  input  logic                 alarm_inh,
  input  logic                 cause_clr,
  restart_alarm_if.master      tmr,
  output logic                 restart_light,
  output logic [CAUSE_W-1:0]   cause,
  output logic                 busy,
  output alarm_state_e         state
);
  localparam int CW = $clog2(max_int(GOJ_CYCLES, GOJ_TIMEOUT) + 1);

  alarm_state_e state_q, state_next;
  logic [CW-1:0] cyc_q, cyc_next;
  logic          ack_q, ack_next;
  logic          ack_to;

  logic mon_en;
  logic nw_alarm, win_close, lock_alarm, idle_alarm, tc_alarm;
  logic saw_tc, saw_non_tc, saw_tc_now, saw_non_tc_now;
  logic [CAUSE_W-1:0] new_bits;
  logic mon_alarm;

  // Monitors only run while idle and the timer is not restarting.
  assign mon_en = (state_q == ST_IDLE) && !tmr.gojam;

  alarm_tick_counter #(.LIMIT(NW_TICKS)) u_nw (
    .clock(clock), .rst(rst), .clr(nw_access || !mon_en),
    .inc(tick), .alarm(nw_alarm)
  );

  alarm_tick_counter #(.LIMIT(TC_TICKS)) u_win (
    .clock(clock), .rst(rst), .clr(!mon_en),
    .inc(tick), .alarm(win_close)
  );

  alarm_tick_counter #(.LIMIT(RUPT_TICKS)) u_lock (
    .clock(clock), .rst(rst), .clr(!in_rupt || !mon_en),
    .inc(tick && in_rupt), .alarm(lock_alarm)
  );

  alarm_tick_counter #(.LIMIT(RUPT_TICKS)) u_idle (
    .clock(clock), .rst(rst), .clr(in_rupt || !mon_en),
    .inc(tick && !in_rupt), .alarm(idle_alarm)
  );

  // An instruction finishing on the closing tick belongs to the closing window.
  assign saw_tc_now     = saw_tc     || (inst_done && inst_is_tc);
  assign saw_non_tc_now = saw_non_tc || (inst_done && !inst_is_tc);
  assign tc_alarm       = win_close && !(saw_tc_now && saw_non_tc_now);

  always_ff @(posedge clock) begin
    if (rst || !mon_en || win_close) begin
      saw_tc     <= 1'b0;
      saw_non_tc <= 1'b0;
    end else begin
      saw_tc     <= saw_tc_now;
      saw_non_tc <= saw_non_tc_now;
    end
  end

  always_comb begin
    new_bits               = '0;
    new_bits[CAUSE_PAR]    = par_fail;
    new_bits[CAUSE_NW]     = nw_alarm;
    new_bits[CAUSE_TC]     = tc_alarm;
    new_bits[CAUSE_LOCK]   = lock_alarm;
    new_bits[CAUSE_NORUPT] = idle_alarm;
    new_bits[CAUSE_ACKTO]  = ack_to;
  end

  assign mon_alarm = |new_bits[CAUSE_NORUPT:CAUSE_PAR];

  always_comb begin
    state_next = state_q;
    cyc_next   = cyc_q;
    ack_next   = ack_q;
    ack_to     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cyc_next = '0;
        ack_next = 1'b0;
        if (mon_alarm && !alarm_inh) state_next = ST_REQ;
      end
      ST_REQ: begin
        // An early gojam is remembered; the request still runs full length.
        if (tmr.gojam) ack_next = 1'b1;
        if (cyc_q == CW'(GOJ_CYCLES - 1)) begin
          state_next = ST_WAIT_ACK;
          cyc_next   = '0;
        end else begin
          cyc_next = cyc_q + CW'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (tmr.gojam || ack_q) begin
          state_next = ST_WAIT_REL;
          cyc_next   = '0;
        end else if (cyc_q == CW'(GOJ_TIMEOUT - 1)) begin
          ack_to     = 1'b1;
          state_next = ST_IDLE;
          cyc_next   = '0;
        end else begin
          cyc_next = cyc_q + CW'(1);
        end
      end
      ST_WAIT_REL: begin
        if (!tmr.gojam) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cyc_q         <= '0;
      ack_q         <= 1'b0;
      tmr.goj1      <= 1'b0;
      cause         <= '0;
      restart_light <= 1'b0;
    end else begin
      state_q       <= state_next;
      cyc_q         <= cyc_next;
      ack_q         <= ack_next;
      tmr.goj1      <= (state_next == ST_REQ);
      // New alarm bits win over a coincident clear.
      cause         <= (cause_clr ? '0 : cause) | new_bits;
      restart_light <= (restart_light && !cause_clr) || (|new_bits);
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign state = state_q;
endmodule

// File: tb/tb_restart_alarm.sv
// Bench for restart_alarm: scenario tasks with expected cause values queued
// as stimulus is driven and popped when the DUT output is sampled.
module tb_restart_alarm;
  import restart_alarm_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst, tick, nw_access, inst_done, inst_is_tc, in_rupt;
  logic par_fail, alarm_inh, cause_clr, gojam;
  logic restart_light, busy;
  logic [5:0] cause;
  alarm_state_e state;

  restart_alarm_if tmr();
  assign tmr.gojam = gojam;

  restart_alarm dut (
    .clock(clock), .rst(rst), .tick(tick), .nw_access(nw_access),
    .inst_done(inst_done), .inst_is_tc(inst_is_tc), .in_rupt(in_rupt),
    .par_fail(par_fail), .alarm_inh(alarm_inh), .cause_clr(cause_clr),
    .tmr(tmr.master), .restart_light(restart_light), .cause(cause),
    .busy(busy), .state(state)
  );

  int total = 0;
  int bad = 0;
  int goj_rises = 0;
  logic [5:0] exp_q[$];

  always @(posedge tmr.goj1) goj_rises++;

  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    tick = 0; nw_access = 0; inst_done = 0; inst_is_tc = 0; in_rupt = 0;
    par_fail = 0; alarm_inh = 0; cause_clr = 0; gojam = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic pulse_clr();
    cyc(); cause_clr = 1;
    cyc(); cause_clr = 0;
  endtask

  // One scan period; returns on the negedge after the tick's active edge.
  task automatic tick_period(input bit feed_nw, input bit feed_tc,
                             input bit feed_non, input bit toggle_rupt,
                             input bit par_on_tick = 1'b0);
    cyc(); inst_done = feed_tc; inst_is_tc = 1;
    cyc(); inst_done = 0; inst_is_tc = 0;
    repeat ($urandom_range(0, 2)) cyc();
    cyc(); tick = 1; nw_access = feed_nw; inst_done = feed_non;
    inst_is_tc = 0; par_fail = par_on_tick;
    cyc(); tick = 0; nw_access = 0; inst_done = 0; par_fail = 0;
    if (toggle_rupt) in_rupt = ~in_rupt;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    cyc(); cyc();
    total++;
    if ({tmr.goj1, restart_light, busy, cause} !== 9'b0 || state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state got goj1=%b light=%b busy=%b cause=%b state=%0d exp all zero/IDLE",
               tmr.goj1, restart_light, busy, cause, state);
    end
    rst = 0;
  endtask

  task automatic test_ticks_only();
    logic [5:0] e;
    do_reset();
    alarm_inh = 1;
    exp_q.push_back(6'b000100);
    exp_q.push_back(6'b000110);
    exp_q.push_back(6'b010110);
    for (int i = 0; i < 3; i++) begin
      tick_period(0, 0, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (cause !== e) begin
        bad++;
        $display("FAIL ticks_only tick%0d got cause=%b exp=%b", i + 1, cause, e);
      end
    end
    total++;
    if (tmr.goj1 !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL inhibit got goj1=%b busy=%b exp 0 0", tmr.goj1, busy);
    end
  endtask

  typedef struct {
    bit nw; bit tc; bit non; bit tog; bit rupt; int n; logic [5:0] bits;
  } mon_case_t;

  task automatic test_monitor_timing();
    mon_case_t tbl[4];
    logic [5:0] e;
    tbl[0] = '{1, 1, 1, 0, 0, 3, 6'b010000};
    tbl[1] = '{0, 1, 1, 1, 0, 2, 6'b000010};
    tbl[2] = '{1, 1, 0, 1, 0, 1, 6'b000100};
    tbl[3] = '{1, 1, 1, 0, 1, 3, 6'b001000};
    do_reset();
    alarm_inh = 1;
    foreach (tbl[k]) begin
      pulse_clr();
      in_rupt = tbl[k].rupt;
      for (int t = 1; t <= tbl[k].n; t++) begin
        exp_q.push_back((t == tbl[k].n) ? tbl[k].bits : 6'b0);
        tick_period(tbl[k].nw, tbl[k].tc, tbl[k].non, tbl[k].tog);
        e = exp_q.pop_front();
        total++;
        if (cause !== e) begin
          bad++;
          $display("FAIL monitor case%0d tick%0d got cause=%b exp=%b", k, t, cause, e);
        end
      end
    end
  endtask

  task automatic test_parity_restart();
    int n;
    do_reset();
    exp_q.push_back(6'b000001);
    cyc(); par_fail = 1;
    cyc(); par_fail = 0;
    total++;
    if (cause !== exp_q[0] || restart_light !== 1'b1 || tmr.goj1 !== 1'b1) begin
      bad++;
      $display("FAIL parity_latch got cause=%b light=%b goj1=%b exp=%b 1 1",
               cause, restart_light, tmr.goj1, exp_q[0]);
    end
    n = 0;
    while (tmr.goj1 === 1'b1 && n < 20) begin n++; cyc(); end
    total++;
    if (n !== 4 || state !== ST_WAIT_ACK) begin
      bad++;
      $display("FAIL goj1_width got %0d cycles state=%0d exp 4 WAIT_ACK", n, state);
    end
    repeat (3) cyc();
    gojam = 1;
    repeat (10) cyc();
    total++;
    if (busy !== 1'b1 || state !== ST_WAIT_REL) begin
      bad++;
      $display("FAIL wait_rel got busy=%b state=%0d exp 1 WAIT_REL", busy, state);
    end
    gojam = 0;
    cyc();
    total++;
    if (busy !== 1'b0 || state !== ST_IDLE || cause !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL release got busy=%b state=%0d cause=%b exp 0 IDLE 000001", busy, state, cause);
    end
  endtask

  task automatic test_legal_run();
    int r0;
    logic [5:0] e;
    do_reset();
    r0 = goj_rises;
    repeat (100) tick_period(1, 1, 1, 1);
    total++;
    if (cause !== 6'b0 || goj_rises !== r0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL legal_run got cause=%b rises=%0d busy=%b exp 0 0 0", cause, goj_rises - r0, busy);
    end
    alarm_inh = 1;
    exp_q.push_back(6'b000000);
    exp_q.push_back(6'b000010);
    for (int i = 0; i < 2; i++) begin
      tick_period(0, 1, 1, 1);
      e = exp_q.pop_front();
      total++;
      if (cause !== e) begin
        bad++;
        $display("FAIL nw_stop tick%0d got cause=%b exp=%b", i + 1, cause, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r0, hi;
    logic [5:0] e;
    do_reset();
    alarm_inh = 1;
    exp_q.push_back(6'b000100);
    tick_period(1, 1, 0, 1);
    e = exp_q.pop_front();
    total++;
    if (cause !== e) begin
      bad++;
      $display("FAIL tc_only got cause=%b exp=%b", cause, e);
    end
    pulse_clr();
    in_rupt = 1;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back((i == 3) ? 6'b001000 : 6'b0);
      tick_period(1, 1, 1, 0);
      e = exp_q.pop_front();
      total++;
      if (cause !== e) begin
        bad++;
        $display("FAIL rupt_lock tick%0d got cause=%b exp=%b", i, cause, e);
      end
    end
    pulse_clr();
    in_rupt = 0;
    alarm_inh = 0;
    r0 = goj_rises;
    tick_period(0, 1, 1, 1);
    exp_q.push_back(6'b000011);
    tick_period(0, 1, 1, 1, 1);
    e = exp_q.pop_front();
    total++;
    if (cause !== e || restart_light !== 1'b1) begin
      bad++;
      $display("FAIL par_nw got cause=%b light=%b exp=%b 1", cause, restart_light, e);
    end
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (tmr.goj1 === 1'b1) hi++;
      cyc();
    end
    total++;
    if (hi !== 4 || goj_rises - r0 !== 1) begin
      bad++;
      $display("FAIL single_restart got high=%0d rises=%0d exp 4 1", hi, goj_rises - r0);
    end
  endtask

  task automatic test_ack_timeout();
    int n, w, r0;
    do_reset();
    cyc(); par_fail = 1;
    cyc(); par_fail = 0;
    n = 0;
    while (tmr.goj1 === 1'b1 && n < 20) begin n++; cyc(); end
    w = 0;
    while (cause[CAUSE_ACKTO] !== 1'b1 && w < 200) begin w++; cyc(); end
    total++;
    if (n !== 4 || w !== 64 || state !== ST_IDLE || busy !== 1'b0) begin
      bad++;
      $display("FAIL ack_timeout got goj=%0d wait=%0d state=%0d busy=%b exp 4 64 IDLE 0",
               n, w, state, busy);
    end
    exp_q.push_back(6'b100001);
    r0 = goj_rises;
    repeat (100) cyc();
    total++;
    if (goj_rises !== r0 || cause !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL no_rerequest got rises=%0d cause=%b exp 0 100001", goj_rises - r0, cause);
    end
  endtask

  task automatic test_reset_and_clr();
    logic [5:0] e;
    do_reset();
    cyc(); par_fail = 1;
    cyc(); par_fail = 0;
    total++;
    if (tmr.goj1 !== 1'b1) begin
      bad++;
      $display("FAIL req_start got goj1=%b exp 1", tmr.goj1);
    end
    rst = 1;
    cyc();
    rst = 0;
    total++;
    if (tmr.goj1 !== 1'b0 || cause !== 6'b0 || restart_light !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_req_reset got goj1=%b cause=%b light=%b busy=%b exp 0 0 0 0",
               tmr.goj1, cause, restart_light, busy);
    end
    alarm_inh = 1;
    tick_period(0, 0, 0, 0);
    exp_q.push_back(6'b000001);
    cyc(); cause_clr = 1; par_fail = 1;
    cyc(); cause_clr = 0; par_fail = 0;
    e = exp_q.pop_front();
    total++;
    if (cause !== e || restart_light !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_set got cause=%b light=%b exp=%b 1", cause, restart_light, e);
    end
  endtask

  initial begin
    test_reset();
    test_ticks_only();
    test_monitor_timing();
    test_parity_restart();
    test_legal_run();
    test_back_to_back();
    test_ack_timeout();
    test_reset_and_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/restart_alarm.md
Name: restart_alarm

Overview:
- Watchdog/alarm block that initiates hardware restarts into the timer.
- Monitors program behaviour against the timer's slow scan strobe:
  - parity fail
  - night watchman
  - TC trap
  - rupt lock / no-rupt
- On any alarm, latches the cause, lights RESTART and drives the goj1 request to the timer.
- Completes the handshake by tracking the timer's gojam response. It is the initiator end of the timer's goj1/gojam restart interface.

Parameters:
- NW_TICKS, 2, scan ticks without nw_access before night-watchman alarm
- TC_TICKS, 1, length in scan ticks of one TC-trap window
- RUPT_TICKS, 3, scan ticks of continuous in_rupt (or continuous absence) before rupt alarm
- GOJ_CYCLES, 4, clock cycles goj1 is held high per request
- GOJ_TIMEOUT, 64, clock cycles to wait for gojam before abandoning request

Ports:
- clock  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- tick  input  1  one-cycle scan strobe from the timer chain
- nw_access  input  1  one-cycle strobe: night-watchman location accessed
- inst_done  input  1  one-cycle strobe: instruction completed
- inst_is_tc  input  1  qualifies inst_done: completed instruction was TC/TCF
- in_rupt  input  1  level: interrupt service active
- par_fail  input  1  one-cycle strobe: memory parity failure
- gojam  input  1  level from timer: restart in progress
- alarm_inh  input  1  level: restart inhibit (test switch)
- cause_clr  input  1  one-cycle strobe: clear cause and restart_light
- goj1  output  1  registered restart request to timer
- restart_light  output  1  sticky RESTART indicator
- cause  output  6  sticky cause bits: [0] parity, [1] night watchman, [2] TC trap, [3] rupt lock, [4] no rupt, [5] gojam ack timeout
- busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Single clock domain on clock. rst is synchronous and active-high.
- On rst: goj1=0, restart_light=0, cause=0, busy=0, FSM=IDLE, all counters and flags=0. rst mid-request drops goj1 on the next edge.

Monitors (evaluated only in IDLE with gojam=0; otherwise all counters/flags held at 0):
- Parity: par_fail sets alarm bit 0.
- Night watchman: nw_cnt increments on tick and clears on nw_access.
  - nw_access wins if coincident with tick (count becomes 0).
  - Alarm bit 1 when a tick would make nw_cnt reach NW_TICKS; nw_cnt then clears.
- TC trap: saw_tc/saw_non_tc flags are set by inst_done qualified by inst_is_tc. win_cnt counts ticks.
  - On the tick ending a window of TC_TICKS ticks, alarm bit 2 if saw_tc=0 or saw_non_tc=0.
  - Flags clear for the next window.
  - An inst_done coincident with the closing tick counts toward the closing window.
- Rupt lock: lock_cnt counts ticks while in_rupt=1 and clears when in_rupt=0. Alarm bit 3 at RUPT_TICKS.
- No rupt: idle_cnt counts ticks while in_rupt=0 and clears when in_rupt=1. Alarm bit 4 at RUPT_TICKS.
- Counter widths are $clog2(limit+1). Counters never wrap: they clear on alarm.

Alarm latching:
- An alarm detected at cycle N ORs its bit into cause and sets restart_light at N+1.
- Simultaneous alarms set all their bits and produce a single restart.
- cause_clr clears cause and restart_light. If a new alarm occurs in the same cycle, the new bits are set (set wins).

FSM IDLE/REQ/WAIT_ACK/WAIT_REL:
- IDLE: any alarm with alarm_inh=0 -> REQ. goj1=1 from N+1. With alarm_inh=1 the cause still latches and the FSM stays IDLE.
- REQ: goj1 held exactly GOJ_CYCLES cycles -> WAIT_ACK, with goj1=0.
- WAIT_ACK: gojam=1 -> WAIT_REL. If GOJ_TIMEOUT cycles pass without gojam: set cause[5], go to IDLE.
  - gojam already high in REQ is accepted; REQ still completes its GOJ_CYCLES first.
- WAIT_REL: gojam=0 -> IDLE. Monitors restart from zero on that cycle.
- No new request is issued outside IDLE. par_fail outside IDLE still ORs cause[0] but does not re-trigger.

Decomposition:
- Shared timer/alarm package holds:
  - FSM state encoding
  - cause bit index constants (CAUSE_PAR..CAUSE_ACKTO)
  - default tick limits
- One natural sub-module: alarm_tick_counter, a saturating-to-limit tick counter with clear, alarm pulse and LIMIT parameter. It is instantiated for nw, win, lock and idle.

Test Plan:
1. rst=1 two cycles, then idle with ticks only, alarm_inh=1 -> cause=6'b010000 only after 3rd tick (no rupt, with TC window/nw also firing per limits); check each bit time individually with other monitors fed legally.
2. par_fail pulse at cycle N, gojam raised 3 cycles after goj1 falls and held 10 cycles -> cause=6'b000001, restart_light=1 at N+1, goj1 high N+1..N+4, busy drops the cycle after gojam falls.
3. nw_access every tick and coincident with tick; inst_done alternating TC/non-TC; in_rupt toggling each tick -> no alarm for 100 ticks. Then stop nw_access -> cause[1] after 2nd tick.
4. Only TC inst_done for one window -> cause[2]. in_rupt held for 3 ticks -> cause[3]. A par_fail and nw alarm in the same cycle -> both bits set, exactly one 4-cycle goj1 pulse.
5. Alarm with gojam never asserted -> after 4 goj1 cycles plus 64 cycles, cause[5]=1, FSM IDLE, no re-request.
6. rst asserted during REQ -> goj1=0, cause=0 next edge. cause_clr coincident with new par_fail -> cause=6'b000001.
